uart_tx_ctrl: RTL and testbench

Upstream control and serialiser stage of the UART transmitter. Accepts a parallel byte with parity configuration and sequences the frame: start, data LSB-first, optional parity, stop. Drives the select, serial-data and parity-bit inputs of the registered 4:1 TX output mux, so TX_out lags this block's outputs by one clock. One bit per clock: clk is the bit clock.

---
 rtl/uart_tx_pkg.sv | 29 ++
 rtl/uart_parity_calc.sv | 25 ++
 rtl/uart_tx_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_tx_pkg                                                                |
// | Shared FSM states, TX mux select codes and parity-type encodings.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // The registered output mux decodes these same values.
  localparam logic [2:0] SEL_START  = 3'b000;
  localparam logic [2:0] SEL_DATA   = 3'b001;
  localparam logic [2:0] SEL_PARITY = 3'b010;
  localparam logic [2:0] SEL_STOP   = 3'b011;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_parity_calc.sv
// +----------------------------------------------------------------------------+
// | uart_parity_calc                                                           |
// | Even/odd parity over a DATA_WIDTH word; shared by transmitter and receiver.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  logic w_xor;

  assign w_xor  = ^data;
  assign parity = (par_typ == PAR_ODD) ? ~w_xor : w_xor;

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// +----------------------------------------------------------------------------+
// | uart_tx_ctrl                                                               |
// | UART TX frame sequencer driving the registered 4:1 output mux.             |
// | Optional macro UART_TX_TWO_STOP_EN: two stop cycles instead of one.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [2:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int              c_cnt_w    = $clog2(DATA_WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_WIDTH - 1);

  tx_state_t              r_state;
  tx_state_t              w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic [c_cnt_w-1:0]     r_bit_cnt;
  logic                   r_par_en;
  logic                   w_accept;
  logic                   w_last_bit;
  logic                   w_parity;
  logic                   w_stop_done;
  logic [2:0]             w_mux_sel_nxt;
  logic                   w_ser_nxt;
  logic                   w_busy_nxt;

  assign w_accept   = (r_state == IDLE) && data_valid;
  assign w_last_bit = (r_bit_cnt == c_last_bit);

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (p_data),
    .par_typ (par_typ),
    .parity  (w_parity)
  );

`ifdef UART_TX_TWO_STOP_EN
  logic r_stop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stop_cnt <= 1'b0;
    end else if (r_state == STOP) begin
      r_stop_cnt <= ~r_stop_cnt;
    end else begin
      r_stop_cnt <= 1'b0;
    end
  end

  assign w_stop_done = r_stop_cnt;
`else
  assign w_stop_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (data_valid) w_state_nxt = START;
      START:   w_state_nxt = DATA;
      DATA:    if (w_last_bit) w_state_nxt = r_par_en ? PARITY : STOP;
      PARITY:  w_state_nxt = STOP;
      STOP:    if (w_stop_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, keeping them Moore
  // while lining them up with the state they describe.
  always_comb begin
    w_mux_sel_nxt = SEL_STOP;
    w_ser_nxt     = 1'b0;
    w_busy_nxt    = 1'b1;
    case (w_state_nxt)
      IDLE:    w_busy_nxt    = 1'b0;
      START:   w_mux_sel_nxt = SEL_START;
      DATA: begin
        w_mux_sel_nxt = SEL_DATA;
        w_ser_nxt     = r_shift[0];
      end
      PARITY:  w_mux_sel_nxt = SEL_PARITY;
      default: w_mux_sel_nxt = SEL_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_sel  <= SEL_STOP;
      ser_data <= 1'b0;
      busy     <= 1'b0;
    end else begin
      mux_sel  <= w_mux_sel_nxt;
      ser_data <= w_ser_nxt;
      busy     <= w_busy_nxt;
    end
  end

  // Shift register presents the next data bit at bit 0 each time DATA is entered or held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_en  <= 1'b0;
      par_bit   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift  <= p_data;
        r_par_en <= par_en;
        par_bit  <= w_parity;
      end else if (w_state_nxt == DATA) begin
        r_shift <= r_shift >> 1;
      end

      if ((r_state == DATA) && !w_last_bit) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end else begin
        r_bit_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_uart_tx_ctrl                                                            |
// | Scoreboard bench for uart_tx_ctrl with a model of the downstream TX mux.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_ctrl;

  localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_CYC = 2;
`else
  localparam int STOP_CYC = 1;
`endif

  typedef struct packed {
    logic       busy;
    logic [2:0] sel;
    logic       ser;
    logic       par;
    logic       line;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic [2:0]    mux_sel;
  logic          ser_data;
  logic          par_bit;
  logic          busy;
  logic          r_tx;
  logic          prev_line;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  uart_tx_ctrl #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream registered 4:1 mux, so the line can be checked one clock late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx <= 1'b1;
    end else begin
      case (mux_sel)
        3'b000:  r_tx <= 1'b0;
        3'b001:  r_tx <= ser_data;
        3'b010:  r_tx <= par_bit;
        default: r_tx <= 1'b1;
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_par);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_sel"}, {29'd0, mux_sel}, 32'd3);
    check_val({tag, "_ser"}, {31'd0, ser_data}, 32'd0);
    check_val({tag, "_par"}, {31'd0, par_bit}, {31'd0, exp_par});
    check_val({tag, "_tx"}, {31'd0, r_tx}, 32'd1);
  endtask

  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
    logic x;
    exp_t e;
    x = 1'b0;
    for (int i = 0; i < DW; i++) x = x ^ d[i];
    if (pt) x = ~x;
    e = '{busy: 1'b1, sel: 3'b000, ser: 1'b0, par: x, line: 1'b0};
    sb.push_back(e);
    for (int k = 0; k < DW; k++) begin
      e = '{busy: 1'b1, sel: 3'b001, ser: d[k], par: x, line: d[k]};
      sb.push_back(e);
    end
    if (pe) begin
      e = '{busy: 1'b1, sel: 3'b010, ser: 1'b0, par: x, line: x};
      sb.push_back(e);
    end
    for (int s = 0; s < STOP_CYC; s++) begin
      e = '{busy: 1'b1, sel: 3'b011, ser: 1'b0, par: x, line: 1'b1};
      sb.push_back(e);
    end
    e = '{busy: 1'b0, sel: 3'b011, ser: 1'b0, par: x, line: 1'b1};
    sb.push_back(e);
  endtask

  // inj_idx: sampled cycle after which a competing request is pulsed.
  // rst_idx: sampled cycle after which reset is asserted mid-frame.
  task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                           input int inj_idx, input int rst_idx);
    exp_t e;
    int   idx;
    @(negedge clk);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    push_frame(d, pe, pt);
    idx = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_val("busy", {31'd0, busy}, {31'd0, e.busy});
      check_val("mux_sel", {29'd0, mux_sel}, {29'd0, e.sel});
      check_val("ser_data", {31'd0, ser_data}, {31'd0, e.ser});
      check_val("par_bit", {31'd0, par_bit}, {31'd0, e.par});
      check_val("tx_line", {31'd0, r_tx}, {31'd0, prev_line});
      prev_line = e.line;
      if (idx == 0) begin
        p_data  = ~d;
        par_en  = ~pe;
        par_typ = ~pt;
      end
      if (idx == inj_idx) begin
        data_valid = 1'b1;
        p_data     = '1;
        par_en     = 1'b1;
        par_typ    = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      if (idx == rst_idx) begin
        rst_n = 1'b0;
        #1;
        check_idle("async_rst", 1'b0);
        sb.delete();
        prev_line = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
      end
      idx++;
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    p_data     = '0;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prev_line  = 1'b1;

    repeat (3) @(negedge clk);
    check_idle("reset", 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("post_reset", 1'b0);

    run_frame(8'hA5, 1'b0, 1'b0, -1, -1);
    run_frame(8'hA5, 1'b1, 1'b0, -1, -1);
    run_frame(8'hA5, 1'b1, 1'b1, -1, -1);
    run_frame(8'h07, 1'b1, 1'b0, -1, -1);
    run_frame(8'h07, 1'b1, 1'b1, -1, -1);
    run_frame(8'h00, 1'b0, 1'b0, 3, -1);
    run_frame(8'hA5, 1'b1, 1'b1, -1, 4);

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_idle("idle_after_rst", 1'b0);
    end

    run_frame(8'h3C, 1'b0, 1'b0, -1, -1);
    for (int i = 0; i < 4; i++) begin
      run_frame(DW'($urandom), 1'($urandom), 1'($urandom), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
